// File: rtl/machine_ctrl_pkg.sv
// Shared definitions for the machine start/stop sequencer: FSM state
// encoding, fault-code constants and the default motor count.
package machine_ctrl_pkg;

    // FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Fault code values: 0 = none, 1..N_MOT = motor index + 1, 8+i = sensor i.
    localparam logic [3:0] FC_NONE      = 4'd0;
    localparam logic [3:0] FC_SENS_BASE = 4'd8;

    // Number of safety sensors (FAIL_SENSn width).
    localparam int N_SENS = 3;

    // Default number of motors on this machine.
    localparam int N_MOT_DEF = 5;

endpackage

// File: rtl/machine_start_sequencer_step_timer.sv
// Reloadable step timer shared by the ramp-up and ramp-down sequences.
// LOAD sets the count to STEP_DLY-1; it then counts down and holds at 0.
// DONE is high while the count reads 0, so the next step fires on the
// edge after the count reaches 0, giving STEP_DLY cycles per step.
module step_timer #(
    parameter int STEP_DLY = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic LOAD,
    output logic DONE
);

    // STEP_DLY = 1 would give a zero-width counter; keep at least one bit.
    localparam int TW = (STEP_DLY > 1) ? $clog2(STEP_DLY) : 1;

    logic [TW-1:0] r_cnt;

    // Down-counter: reload on LOAD, otherwise decrement until it reaches 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (LOAD) begin
            r_cnt <= TW'(STEP_DLY - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign DONE = (r_cnt == '0);

endmodule

// File: rtl/machine_start_sequencer.sv
// Sequenced start/stop and fault controller for the motor enables.
// Motors come up one at a time every STEP_DLY cycles and go down in
// reverse order; any sensor fault, or an error on an enabled motor,
// drops every enable on the next edge and latches the first fault cause.
module machine_start_sequencer
    import machine_ctrl_pkg::*;
#(
    parameter int N_MOT    = N_MOT_DEF,
    parameter int STEP_DLY = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               CLR,
    input  logic [N_MOT-1:0]   MOT_ERR,
    input  logic [N_SENS-1:0]  FAIL_SENSn,
    output logic [N_MOT-1:0]   MOT_ENA,
    output logic               RUNNING,
    output logic               BUSY,
    output logic               FAULT,
    output logic [3:0]         FAULT_CODE,
    output logic [2:0]         o_dbg_state
);

    state_t           r_state;
    logic [N_MOT-1:0] r_mot_ena;
    logic             r_running;
    logic             r_busy;
    logic             r_fault;
    logic [3:0]       r_code;

    state_t           w_state_nxt;
    logic [N_MOT-1:0] w_ena_nxt;
    logic [3:0]       w_code_nxt;
    logic             w_load;
    logic             w_step_done;
    logic             w_fault;
    logic [3:0]       w_fault_code;
    logic [N_MOT-1:0] w_mot_flt;
    logic [N_MOT-1:0] w_ena_up;
    logic [N_MOT-1:0] w_ena_dn;

    // Enables always form a contiguous run from bit 0, so a single shift
    // sets the next-higher bit or clears the highest set bit.
    assign w_ena_up = (r_mot_ena << 1) | N_MOT'(1);
    assign w_ena_dn = r_mot_ena >> 1;

    // Errors of motors that are not enabled are ignored.
    assign w_mot_flt = MOT_ERR & r_mot_ena;

    step_timer #(
        .STEP_DLY (STEP_DLY)
    ) u_step_timer (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (w_load),
        .DONE (w_step_done)
    );

    // Fault encoder: sensors beat motors, lowest index wins in each group.
    // Loops run high-to-low so the lowest index is the last (winning) write.
    always_comb begin
        w_fault_code = FC_NONE;
        for (int k = N_MOT - 1; k >= 0; k--) begin
            if (w_mot_flt[k]) begin
                w_fault_code = 4'(k + 1);
            end
        end
        for (int i = N_SENS - 1; i >= 0; i--) begin
            if (!FAIL_SENSn[i]) begin
                w_fault_code = FC_SENS_BASE + 4'(i);
            end
        end
    end

    assign w_fault = (~FAIL_SENSn != '0) || (w_mot_flt != '0);

    // State register plus the registered outputs derived from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_mot_ena <= '0;
            r_running <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
            r_code    <= FC_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_mot_ena <= w_ena_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_busy    <= (w_state_nxt == ST_RAMP_UP) || (w_state_nxt == ST_RAMP_DOWN);
            r_fault   <= (w_state_nxt == ST_FAULT);
            r_code    <= w_code_nxt;
        end
    end

    // Next-state logic: fault beats every command; STOP beats START in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (START && !STOP) begin
                    w_state_nxt = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (w_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (STOP) begin
                    w_state_nxt = (w_ena_dn == '0) ? ST_IDLE : ST_RAMP_DOWN;
                end else if (w_step_done && r_mot_ena[N_MOT-1]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (STOP) begin
                    w_state_nxt = (w_ena_dn == '0) ? ST_IDLE : ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (w_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_step_done && (w_ena_dn == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (CLR && !w_fault) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: enable shifting, step-timer reloads and fault-code latch.
    always_comb begin
        w_ena_nxt  = r_mot_ena;
        w_code_nxt = r_code;
        w_load     = 1'b0;
        if (w_state_nxt == ST_FAULT) begin
            w_ena_nxt = '0;
            // Only the transition into FAULT captures a code; later faults
            // while already in FAULT leave the first cause in place.
            if (r_state != ST_FAULT) begin
                w_code_nxt = w_fault_code;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_RAMP_UP) begin
                        w_ena_nxt = N_MOT'(1);
                        w_load    = 1'b1;
                    end
                end
                ST_RAMP_UP: begin
                    if (STOP) begin
                        w_ena_nxt = w_ena_dn;
                        w_load    = 1'b1;
                    end else if (w_step_done && !r_mot_ena[N_MOT-1]) begin
                        w_ena_nxt = w_ena_up;
                        w_load    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        w_ena_nxt = w_ena_dn;
                        w_load    = 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (w_step_done) begin
                        w_ena_nxt = w_ena_dn;
                        w_load    = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (w_state_nxt == ST_IDLE) begin
                        w_code_nxt = FC_NONE;
                    end
                end
                default: begin
                    w_ena_nxt = '0;
                end
            endcase
        end
    end

    assign MOT_ENA     = r_mot_ena;
    assign RUNNING     = r_running;
    assign BUSY        = r_busy;
    assign FAULT       = r_fault;
    assign FAULT_CODE  = r_code;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_machine_start_sequencer.sv
// Directed testbench for machine_start_sequencer with STEP_DLY=4, N_MOT=5.
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// so "edge e" below means the values just after rising edge e.
module tb_machine_start_sequencer;

    localparam int N_MOT    = 5;
    localparam int STEP_DLY = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             clr;
    logic [N_MOT-1:0] mot_err;
    logic [2:0]       fail_sensn;
    logic [N_MOT-1:0] mot_ena;
    logic             running;
    logic             busy;
    logic             fault;
    logic [3:0]       fault_code;
    logic [2:0]       dbg_state;

    int n_chk = 0;
    int n_err = 0;

    machine_start_sequencer #(
        .N_MOT    (N_MOT),
        .STEP_DLY (STEP_DLY)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .START       (start),
        .STOP        (stop),
        .CLR         (clr),
        .MOT_ERR     (mot_err),
        .FAIL_SENSn  (fail_sensn),
        .MOT_ENA     (mot_ena),
        .RUNNING     (running),
        .BUSY        (busy),
        .FAULT       (fault),
        .FAULT_CODE  (fault_code),
        .o_dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All outputs packed: {MOT_ENA, RUNNING, BUSY, FAULT, FAULT_CODE, state}.
    function automatic logic [14:0] all_out();
        return {mot_ena, running, busy, fault, fault_code, dbg_state};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", all_out(), 15'h0);
        end
        tick();
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL reset_idle_hold: got %h expected %h", all_out(), 15'h0);
        end
    endtask

    // START at edge 0, enables at 0,4,8,12,16, RUN at 20; stop at edge 30.
    task automatic test_start_and_stop();
        logic [N_MOT-1:0] exp_ena;
        int               n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if ({mot_ena, busy, running, dbg_state} !== {5'b00001, 1'b1, 1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL start_edge0: got ena=%b busy=%b run=%b st=%0d", mot_ena, busy, running, dbg_state);
        end
        for (int e = 1; e <= 20; e++) begin
            tick();
            n = (e / 4) + 1;
            if (n > 5) n = 5;
            exp_ena = 5'((1 << n) - 1);
            n_chk++;
            if ({mot_ena, busy, running} !== {exp_ena, (e < 20), (e >= 20)}) begin
                n_err++;
                $display("FAIL ramp_up_edge%0d: got ena=%b busy=%b run=%b expected ena=%b busy=%b run=%b",
                         e, mot_ena, busy, running, exp_ena, (e < 20), (e >= 20));
            end
        end
        repeat (9) tick();
        n_chk++;
        if ({mot_ena, running, dbg_state} !== {5'b11111, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL run_hold: got ena=%b run=%b st=%0d", mot_ena, running, dbg_state);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_chk++;
        if ({mot_ena, busy, running, dbg_state} !== {5'b01111, 1'b1, 1'b0, 3'd3}) begin
            n_err++;
            $display("FAIL stop_edge30: got ena=%b busy=%b run=%b st=%0d", mot_ena, busy, running, dbg_state);
        end
        for (int e = 31; e <= 46; e++) begin
            tick();
            n = 4 - ((e - 30) / 4);
            exp_ena = 5'((1 << n) - 1);
            n_chk++;
            if ({mot_ena, busy, dbg_state} !== {exp_ena, (e < 46), ((e < 46) ? 3'd3 : 3'd0)}) begin
                n_err++;
                $display("FAIL ramp_down_edge%0d: got ena=%b busy=%b st=%0d expected ena=%b",
                         e, mot_ena, busy, dbg_state, exp_ena);
            end
        end
    endtask

    task automatic test_motor_fault_ramp();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_chk++;
        if (mot_ena !== 5'b00011) begin
            n_err++;
            $display("FAIL mf_pre_ena: got %b expected %b", mot_ena, 5'b00011);
        end
        // Error on motor 4, not yet enabled: ignored.
        mot_err = 5'b10000;
        tick();
        n_chk++;
        if ({mot_ena, fault, dbg_state} !== {5'b00011, 1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL mf_disabled_ignored: got ena=%b fault=%b st=%0d", mot_ena, fault, dbg_state);
        end
        mot_err = 5'b00010;
        tick();
        n_chk++;
        if (all_out() !== {5'b00000, 1'b0, 1'b0, 1'b1, 4'd2, 3'd4}) begin
            n_err++;
            $display("FAIL mf_motor1_fault: got ena=%b busy=%b fault=%b code=%0d st=%0d expected code=2",
                     mot_ena, busy, fault, fault_code, dbg_state);
        end
        mot_err = 5'b00001;
        tick();
        n_chk++;
        if ({fault, fault_code} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL mf_code_hold: got fault=%b code=%0d expected code=2", fault, fault_code);
        end
        mot_err = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL mf_clear: got %h expected %h", all_out(), 15'h0);
        end
    endtask

    task automatic test_sensor_priority_and_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        n_chk++;
        if ({running, dbg_state} !== {1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL sp_in_run: got run=%b st=%0d", running, dbg_state);
        end
        fail_sensn = 3'b101;
        mot_err    = 5'b00001;
        tick();
        n_chk++;
        if (all_out() !== {5'b00000, 1'b0, 1'b0, 1'b1, 4'd9, 3'd4}) begin
            n_err++;
            $display("FAIL sp_sensor_wins: got ena=%b fault=%b code=%0d st=%0d expected code=9",
                     mot_ena, fault, fault_code, dbg_state);
        end
        mot_err = 5'b00100;
        tick();
        n_chk++;
        if (fault_code !== 4'd9) begin
            n_err++;
            $display("FAIL sp_code_latched: got %0d expected 9", fault_code);
        end
        // CLR while the sensor is still failing is ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if ({fault, fault_code, dbg_state} !== {1'b1, 4'd9, 3'd4}) begin
            n_err++;
            $display("FAIL fc_clr_ignored: got fault=%b code=%0d st=%0d", fault, fault_code, dbg_state);
        end
        fail_sensn = 3'b111;
        mot_err    = '0;
        tick();
        n_chk++;
        if ({fault, fault_code} !== {1'b1, 4'd9}) begin
            n_err++;
            $display("FAIL fc_no_auto_clear: got fault=%b code=%0d", fault, fault_code);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL fc_cleared: got %h expected %h", all_out(), 15'h0);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL stop_beats_start: got %h expected %h", all_out(), 15'h0);
        end
    endtask

    task automatic test_idle_sensor_fault();
        fail_sensn = 3'b010;
        tick();
        n_chk++;
        if ({fault, fault_code, dbg_state} !== {1'b1, 4'd8, 3'd4}) begin
            n_err++;
            $display("FAIL idle_sensor_fault: got fault=%b code=%0d st=%0d expected code=8",
                     fault, fault_code, dbg_state);
        end
        fail_sensn = 3'b111;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL idle_sensor_clear: got %h expected %h", all_out(), 15'h0);
        end
    endtask

    task automatic test_fault_beats_stop();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        stop    = 1'b1;
        mot_err = 5'b10000;
        tick();
        stop    = 1'b0;
        mot_err = '0;
        n_chk++;
        if (all_out() !== {5'b00000, 1'b0, 1'b0, 1'b1, 4'd5, 3'd4}) begin
            n_err++;
            $display("FAIL fault_beats_stop: got ena=%b fault=%b code=%0d st=%0d expected code=5",
                     mot_ena, fault, fault_code, dbg_state);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_chk++;
        if (mot_ena !== 5'b00111) begin
            n_err++;
            $display("FAIL rr_pre_ena: got %b expected %b", mot_ena, 5'b00111);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (all_out() !== 15'h0) begin
            n_err++;
            $display("FAIL rr_reset: got %h expected %h", all_out(), 15'h0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if ({mot_ena, busy, dbg_state} !== {5'b00001, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL rr_restart: got ena=%b busy=%b st=%0d", mot_ena, busy, dbg_state);
        end
        repeat (4) tick();
        n_chk++;
        if (mot_ena !== 5'b00011) begin
            n_err++;
            $display("FAIL rr_restart_step: got %b expected %b", mot_ena, 5'b00011);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        clr        = 1'b0;
        mot_err    = '0;
        fail_sensn = 3'b111;
        test_reset();
        test_start_and_stop();
        test_motor_fault_ramp();
        test_sensor_priority_and_clear();
        test_idle_sensor_fault();
        test_fault_beats_stop();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
